// File: rtl/calc_alu_seq_if.sv
// Calculator ALU bus: start request and operands from the input sequencer,
// result and status flags back to it.
interface calc_alu_seq_if #(
    parameter int unsigned W_IN  = 4,
    parameter int unsigned W_OUT = 8
);
    logic             start;
    logic [W_IN-1:0]  operand1;
    logic [W_IN-1:0]  operand2;
    logic [2:0]       md_operator;
    logic [W_OUT-1:0] result;
    logic             busy;
    logic             valid;
    logic             neg;
    logic             overflow;
    logic             div_zero;

    // Sequencer side
    modport master (
        output start, operand1, operand2, md_operator,
        input  result, busy, valid, neg, overflow, div_zero
    );

    // ALU side
    modport slave (
        input  start, operand1, operand2, md_operator,
        output result, busy, valid, neg, overflow, div_zero
    );
endinterface

// File: rtl/calc_alu_seq.sv
// Multi-cycle calculator ALU. Latches operands on a rising start edge, runs the
// selected operation (iterative for mul/div/pow/fact/gcd) and holds the result
// with valid=1 until the next accepted start.
module calc_alu_seq #(
    parameter int unsigned W_IN  = 4,
    parameter int unsigned W_OUT = 8
) (
    input logic           clock,
    input logic           reset,
    calc_alu_seq_if.slave bus
);
    localparam int unsigned       W_PROD    = W_IN + W_OUT;
    localparam int unsigned       W_STEP    = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam logic [W_STEP-1:0] STEP_LAST = W_STEP'(W_IN - 1);
    localparam logic [W_OUT-1:0]  SAT       = '1;
    localparam logic [W_PROD-1:0] SAT_WIDE  = W_PROD'(SAT);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQR  = 3'b100;
    localparam logic [2:0] OP_POW  = 3'b101;
    localparam logic [2:0] OP_FACT = 3'b110;
    localparam logic [2:0] OP_GCD  = 3'b111;

    typedef enum logic [2:0] {
        StIdle, StLoad, StMul, StDiv, StPow, StFact, StGcd, StDone
    } state_e;

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [W_IN-1:0]   a_q, a_d;
    logic [W_IN-1:0]   b_q, b_d;
    logic [2:0]        op_q, op_d;
    logic [W_OUT-1:0]  mcand_q, mcand_d;   // multiplicand; doubles as pow/fact accumulator
    logic [W_IN-1:0]   mplier_q, mplier_d;
    logic [W_PROD-1:0] prod_q, prod_d;
    logic [W_STEP-1:0] step_q, step_d;
    logic [W_IN-1:0]   count_q, count_d;   // multiplies left in a pow/fact chain
    logic [W_IN-1:0]   rem_q, rem_d;
    logic [W_IN-1:0]   quot_q, quot_d;
    logic [W_OUT-1:0]  result_q, result_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              dz_q, dz_d;

    logic              accept;
    logic [W_PROD-1:0] prod_next;
    logic              prod_sat;
    logic [W_OUT-1:0]  acc_next;
    logic [W_IN:0]     div_trial;
    logic [W_IN:0]     div_diff;
    logic              div_fits;
    logic [W_IN-1:0]   rem_next;
    logic [W_IN-1:0]   quot_next;

    // Only a fresh rising edge of start, and only while not computing
    assign accept = bus.start && !start_q && (state_q == StIdle || state_q == StDone);

    // Shift-add and restoring-division step datapath
    always_comb begin
        prod_next = prod_q;
        if (mplier_q[step_q]) begin
            prod_next = prod_q + (W_PROD'(mcand_q) << step_q);
        end
        prod_sat = prod_next > SAT_WIDE;
        // Once a chain has saturated the accumulator stays pinned at SAT
        acc_next  = (ovf_q || prod_sat) ? SAT : prod_next[W_OUT-1:0];
        div_trial = {rem_q, quot_q[W_IN-1]};
        div_diff  = div_trial - {1'b0, b_q};
        div_fits  = div_trial >= {1'b0, b_q};
        rem_next  = div_fits ? div_diff[W_IN-1:0] : div_trial[W_IN-1:0];
        quot_next = {quot_q[W_IN-2:0], div_fits};
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        start_d  = bus.start;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        step_d   = step_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    a_d     = bus.operand1;
                    b_d     = bus.operand2;
                    op_d    = bus.md_operator;
                    neg_d   = 1'b0;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                prod_d   = '0;
                step_d   = '0;
                mcand_d  = W_OUT'(a_q);
                mplier_d = b_q;
                case (op_q)
                    // Add/sub resolve in the load cycle itself
                    OP_ADD: begin
                        result_d = W_OUT'(a_q) + W_OUT'(b_q);
                        state_d  = StDone;
                    end
                    OP_SUB: begin
                        result_d = W_OUT'(a_q) - W_OUT'(b_q);
                        neg_d    = a_q < b_q;
                        state_d  = StDone;
                    end
                    OP_MUL: state_d = StMul;
                    OP_SQR: begin
                        mplier_d = a_q;
                        state_d  = StMul;
                    end
                    OP_DIV: begin
                        if (b_q == '0) begin
                            result_d = SAT;
                            dz_d     = 1'b1;
                            state_d  = StDone;
                        end else begin
                            rem_d   = '0;
                            quot_d  = a_q;
                            state_d = StDiv;
                        end
                    end
                    OP_POW: begin
                        mcand_d  = W_OUT'(1);
                        mplier_d = a_q;
                        count_d  = b_q;
                        if (b_q == '0) begin
                            result_d = W_OUT'(1);
                            state_d  = StDone;
                        end else begin
                            state_d = StPow;
                        end
                    end
                    OP_FACT: begin
                        mcand_d  = W_OUT'(1);
                        mplier_d = a_q;
                        count_d  = a_q;
                        if (a_q == '0) begin
                            result_d = W_OUT'(1);
                            state_d  = StDone;
                        end else begin
                            state_d = StFact;
                        end
                    end
                    default: state_d = StGcd;
                endcase
            end
            StMul: begin
                prod_d = prod_next;
                step_d = step_q + W_STEP'(1);
                if (step_q == STEP_LAST) begin
                    result_d = acc_next;
                    ovf_d    = ovf_q || prod_sat;
                    state_d  = StDone;
                end
            end
            StDiv: begin
                rem_d  = rem_next;
                quot_d = quot_next;
                step_d = step_q + W_STEP'(1);
                if (step_q == STEP_LAST) begin
                    result_d = W_OUT'({rem_next, quot_next});
                    state_d  = StDone;
                end
            end
            StPow, StFact: begin
                prod_d = prod_next;
                step_d = step_q + W_STEP'(1);
                if (step_q == STEP_LAST) begin
                    // One full multiply done: fold it into the accumulator
                    ovf_d    = ovf_q || prod_sat;
                    mcand_d  = acc_next;
                    prod_d   = '0;
                    step_d   = '0;
                    count_d  = count_q - W_IN'(1);
                    mplier_d = (state_q == StFact) ? count_q - W_IN'(1) : a_q;
                    if (count_q == W_IN'(1)) begin
                        result_d = acc_next;
                        state_d  = StDone;
                    end
                end
            end
            StGcd: begin
                if (a_q == b_q || b_q == '0) begin
                    result_d = W_OUT'(a_q);
                    state_d  = StDone;
                end else if (a_q == '0) begin
                    result_d = W_OUT'(b_q);
                    state_d  = StDone;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            step_q   <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            step_q   <= step_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
        end
    end

    // Status outputs derived from state; busy and valid are mutually exclusive
    always_comb begin
        bus.result   = result_q;
        bus.busy     = (state_q != StIdle) && (state_q != StDone);
        bus.valid    = (state_q == StDone);
        bus.neg      = neg_q;
        bus.overflow = ovf_q;
        bus.div_zero = dz_q;
    end
endmodule

// File: tb/tb_calc_alu_seq.sv
// Scoreboard bench for calc_alu_seq: stimulus pushes reference results,
// a monitor pops and compares them whenever valid rises.
module tb_calc_alu_seq;
    localparam int unsigned W_IN  = 4;
    localparam int unsigned W_OUT = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    calc_alu_seq_if #(.W_IN(W_IN), .W_OUT(W_OUT)) bus ();

    calc_alu_seq #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        string name;
        int    result;
        bit    neg;
        bit    ovf;
        bit    dz;
        int    lat;
        bit    lat_max;
        int    t0;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model straight from the arithmetic definitions
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   acc;
        bit   sat;
        int   x;
        int   y;
        int   t;
        e.name = ""; e.result = 0; e.neg = 0; e.ovf = 0; e.dz = 0;
        e.lat = 2; e.lat_max = 0; e.t0 = 0;
        case (op)
            0: begin e.name = "add"; e.result = a + b; end
            1: begin e.name = "sub"; e.result = (a - b) & 255; e.neg = (a < b); end
            2: begin e.name = "mul"; e.result = a * b; e.lat = 6; end
            3: begin
                e.name = "div";
                if (b == 0) begin e.result = 255; e.dz = 1; end
                else begin e.result = (a % b) * 16 + a / b; e.lat = 6; end
            end
            4: begin e.name = "sqr"; e.result = a * a; e.lat = 6; end
            5, 6: begin
                acc = 1; sat = 0;
                e.name = (op == 5) ? "pow" : "fact";
                for (int i = 0; i < ((op == 5) ? b : a); i++) begin
                    if (sat) acc = 255;
                    else begin
                        acc = acc * ((op == 5) ? a : (a - i));
                        if (acc > 255) begin acc = 255; sat = 1; end
                    end
                end
                e.result = acc; e.ovf = sat;
                e.lat = 2 + 4 * ((op == 5) ? b : a);
            end
            default: begin
                e.name = "gcd"; x = a; y = b;
                while (y != 0) begin t = x % y; x = y; y = t; end
                e.result = x; e.lat = 18; e.lat_max = 1;
            end
        endcase
        return e;
    endfunction

    // Monitor: compare on every rising valid, and check busy/valid exclusivity
    initial begin : monitor
        bit   valid_prev;
        exp_t e;
        int   lat;
        valid_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("busy_valid_exclusive", int'(bus.busy && bus.valid), 0);
                if (bus.valid && !valid_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", int'(bus.result), -1);
                    end else begin
                        e = sb.pop_front();
                        lat = cyc - e.t0;
                        check({e.name, "_result"}, int'(bus.result), e.result);
                        check({e.name, "_neg"}, int'(bus.neg), int'(e.neg));
                        check({e.name, "_overflow"}, int'(bus.overflow), int'(e.ovf));
                        check({e.name, "_div_zero"}, int'(bus.div_zero), int'(e.dz));
                        if (e.lat_max) check({e.name, "_latency_bounded"}, int'(lat <= e.lat), 1);
                        else check({e.name, "_latency"}, lat, e.lat);
                    end
                end
            end
            valid_prev = bus.valid;
        end
    end

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clock);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check({name, "_timeout"}, 0, 1);
            sb.delete();
        end
    endtask

    // Issue one operation; with poke, raise start again mid-computation
    task automatic run_op(input int a, input int b, input int op, input bit poke);
        exp_t e;
        @(negedge clock);
        bus.operand1    = 4'(a);
        bus.operand2    = 4'(b);
        bus.md_operator = 3'(op);
        bus.start       = 1'b1;
        e = model(a, b, op);
        e.t0 = cyc;
        sb.push_back(e);
        @(negedge clock);
        check({e.name, "_busy_t1"}, int'(bus.busy), 1);
        check({e.name, "_valid_t1"}, int'(bus.valid), 0);
        bus.start       = 1'b0;
        // Scramble inputs: the operation must use the latched values
        bus.operand1    = 4'($urandom);
        bus.operand2    = 4'($urandom);
        bus.md_operator = 3'($urandom);
        if (poke) begin
            repeat (2) @(negedge clock);
            check({e.name, "_busy_at_poke"}, int'(bus.busy), 1);
            bus.start = 1'b1;
        end
        wait_drain(e.name);
        if (poke) begin
            repeat (3) @(negedge clock);
            check({e.name, "_valid_held"}, int'(bus.valid), 1);
            check({e.name, "_result_held"}, int'(bus.result), e.result);
            bus.start = 1'b0;
        end
    endtask

    initial begin : stimulus
        exp_t e;
        int   t0;
        bus.start = 1'b0; bus.operand1 = '0; bus.operand2 = '0; bus.md_operator = '0;
        repeat (3) @(negedge clock);
        check("rst_result", int'(bus.result), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_neg", int'(bus.neg), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_div_zero", int'(bus.div_zero), 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_op(9, 6, 0, 0);
        run_op(3, 5, 1, 0);
        run_op(15, 15, 2, 1);
        run_op(13, 4, 3, 0);
        run_op(7, 0, 3, 0);
        run_op(13, 13, 4, 0);
        run_op(3, 5, 5, 0);
        run_op(2, 9, 5, 0);
        run_op(4, 0, 5, 0);
        run_op(0, 0, 5, 0);
        run_op(5, 0, 6, 0);
        run_op(7, 0, 6, 0);
        run_op(0, 3, 6, 0);
        run_op(1, 3, 6, 0);
        run_op(12, 8, 7, 0);
        run_op(0, 0, 7, 0);
        run_op(15, 1, 7, 0);
        run_op(0, 9, 7, 0);
        run_op(7, 0, 7, 0);

        // Reset in the middle of POW 2^9: no result may appear
        @(negedge clock);
        bus.operand1 = 4'd2; bus.operand2 = 4'd9; bus.md_operator = 3'd5; bus.start = 1'b1;
        t0 = cyc;
        @(negedge clock);
        bus.start = 1'b0;
        while (cyc < t0 + 10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_valid", int'(bus.valid), 0);
        check("midrst_result", int'(bus.result), 0);
        check("midrst_overflow", int'(bus.overflow), 0);
        // Start already high when reset releases counts as an edge
        bus.operand1 = 4'd9; bus.operand2 = 4'd6; bus.md_operator = 3'd0; bus.start = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        e = model(9, 6, 0);
        e.t0 = cyc;
        sb.push_back(e);
        @(negedge clock);
        bus.start = 1'b0;
        wait_drain("post_reset_add");

        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                   int'($urandom_range(7, 0)), 0);
            repeat ($urandom_range(3, 0)) @(negedge clock);
        end

        repeat (5) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
